// File: rtl/count_sequencer_pkg.sv
// count_sequencer_pkg: counter width default and sequencer state encoding
package count_sequencer_pkg;
    localparam int CNT_WIDTH = 4;
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_COUNT = 3'd2;
    localparam state_t ST_INCR  = 3'd3;
    localparam state_t ST_DONE  = 3'd4;
endpackage

// File: rtl/count_sequencer_step_edge_detect.sv
// count_sequencer_step_edge_detect: one-cycle pulse on each 0->1 of step
module count_sequencer_step_edge_detect (
    input  logic clk,
    input  logic clear,
    input  logic step,
    output logic rise
);
    logic step_q, step_d;
    always_comb step_d = step;
    always_ff @(posedge clk) step_q <= clear ? 1'b0 : step_d;
    assign rise = step & ~step_q;
endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: presets an up-counter, turns step edges into incr pulses, flags done/wrap
module count_sequencer
    import count_sequencer_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] stop_val,
    input  logic             step,
    input  logic             abort,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] cnt_d,
    output logic             cnt_load,
    output logic             cnt_clear,
    output logic             cnt_incr,
    output logic             busy,
    output logic             done,
    output logic             wrapped
);
    state_t state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d, stop_q, stop_d;
    logic cnt_load_q, cnt_load_d, cnt_clear_q, cnt_clear_d, cnt_incr_q, cnt_incr_d;
    logic busy_q, busy_d, done_q, done_d, wrapped_q, wrapped_d;
    logic rise, accept, active, counting, match;
    count_sequencer_step_edge_detect u_edge (
        .clk  (clk),
        .clear(clear),
        .step (step),
        .rise (rise)
    );
    assign accept   = state_q == ST_IDLE && start;
    assign active   = state_q == ST_LOAD || state_q == ST_COUNT || state_q == ST_INCR;
    assign counting = state_q == ST_COUNT && !abort;
    assign match    = q_in == stop_q;
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= ST_IDLE;
            start_q     <= '0;
            stop_q      <= '0;
            cnt_load_q  <= 1'b0;
            cnt_clear_q <= 1'b0;
            cnt_incr_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wrapped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            cnt_load_q  <= cnt_load_d;
            cnt_clear_q <= cnt_clear_d;
            cnt_incr_q  <= cnt_incr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wrapped_q   <= wrapped_d;
        end
    end
    // abort outranks a stop match, which outranks a step edge
    always_comb begin
        state_d = ST_IDLE;
        unique case (state_q)
            ST_IDLE:  state_d = start ? ST_LOAD : ST_IDLE;
            ST_LOAD:  state_d = abort ? ST_IDLE : ST_COUNT;
            ST_COUNT: state_d = abort ? ST_IDLE : match ? ST_DONE : rise ? ST_INCR : ST_COUNT;
            ST_INCR:  state_d = abort ? ST_IDLE : ST_COUNT;
            default:  state_d = ST_IDLE;
        endcase
    end
    always_comb begin
        start_d     = accept ? start_val : start_q;
        stop_d      = accept ? stop_val : stop_q;
        cnt_load_d  = accept;
        cnt_clear_d = active && abort;
        cnt_incr_d  = counting && !match && rise;
        done_d      = counting && match;
        busy_d      = state_d != ST_IDLE;
        wrapped_d   = accept ? 1'b0 : wrapped_q | (cnt_incr_d && &q_in);
    end
    assign cnt_d     = start_q;
    assign cnt_load  = cnt_load_q;
    assign cnt_clear = cnt_clear_q;
    assign cnt_incr  = cnt_incr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign wrapped   = wrapped_q;
endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed checks of the sequencer driving a behavioural 4-bit counter
module tb_count_sequencer;
    logic clk = 1'b0, clear = 1'b1, start = 1'b0, step = 1'b0, abort = 1'b0;
    logic [3:0] start_val = '0, stop_val = '0, q, cnt_d;
    logic cnt_load, cnt_clear, cnt_incr, busy, done, wrapped;
    int n_chk = 0, n_err = 0, n_incr = 0, base;
    count_sequencer #(.WIDTH(4)) dut (
        .clk      (clk),
        .clear    (clear),
        .start    (start),
        .start_val(start_val),
        .stop_val (stop_val),
        .step     (step),
        .abort    (abort),
        .q_in     (q),
        .cnt_d    (cnt_d),
        .cnt_load (cnt_load),
        .cnt_clear(cnt_clear),
        .cnt_incr (cnt_incr),
        .busy     (busy),
        .done     (done),
        .wrapped  (wrapped)
    );
    always #5 clk = ~clk;
    always_ff @(posedge clk)
        if (clear || cnt_clear) q <= '0;
        else if (cnt_load) q <= cnt_d;
        else if (cnt_incr) q <= q + 4'd1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    always @(negedge clk) begin
        check("strobe_excl", 32'(int'(cnt_load) + int'(cnt_clear) + int'(cnt_incr) <= 1), 1);
        if (cnt_incr) n_incr++;
    end
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask
    task automatic begin_seq(input logic [3:0] sv, input logic [3:0] ev);
        start = 1'b1; start_val = sv; stop_val = ev;
        tick();
        start = 1'b0;
        check("load_pulse", cnt_load, 1);
        check("load_d", cnt_d, sv);
        check("load_busy", busy, 1);
        check("load_wrap_clr", wrapped, 0);
        tick();
        check("count_q", q, sv);
        check("load_end", cnt_load, 0);
    endtask
    task automatic pulse(input logic [3:0] exp_q);
        step = 1'b1;
        tick();
        check("incr_pulse", cnt_incr, 1);
        step = 1'b0;
        tick();
        check("incr_end", cnt_incr, 0);
        check("q_after_incr", q, exp_q);
    endtask
    initial begin
        tick(2);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wrap", wrapped, 0);
        check("rst_load", cnt_load, 0);
        check("rst_d", cnt_d, 0);
        clear = 1'b0;
        tick();
        // 3 -> 6 with three steps
        base = n_incr;
        begin_seq(4'd3, 4'd6);
        pulse(4'd4); pulse(4'd5); pulse(4'd6);
        check("t1_pre_done", done, 0);
        tick();
        check("t1_done", done, 1);
        check("t1_done_busy", busy, 1);
        tick();
        check("t1_done_end", done, 0);
        check("t1_idle", busy, 0);
        check("t1_incrs", n_incr - base, 3);
        // start == stop: done in cycle 3, no increments
        base = n_incr;
        begin_seq(4'd5, 4'd5);
        check("t2_c2_done", done, 0);
        tick();
        check("t2_c3_done", done, 1);
        tick();
        check("t2_idle", busy, 0);
        check("t2_incrs", n_incr - base, 0);
        // 14 -> 1 through the wrap
        begin_seq(4'd14, 4'd1);
        pulse(4'd15);
        check("t3_nowrap", wrapped, 0);
        step = 1'b1;
        tick();
        check("t3_wrap_set", wrapped, 1);
        step = 1'b0;
        tick();
        check("t3_q0", q, 0);
        pulse(4'd1);
        tick();
        check("t3_done", done, 1);
        check("t3_wrap_kept", wrapped, 1);
        tick();
        check("t3_idle", busy, 0);
        check("t3_wrap_sticky", wrapped, 1);
        // held step yields one increment, then abort at q=4
        base = n_incr;
        begin_seq(4'd0, 4'd9);
        step = 1'b1;
        tick(10);
        step = 1'b0;
        tick();
        check("t4_held_q", q, 1);
        check("t4_held_incrs", n_incr - base, 1);
        pulse(4'd2); pulse(4'd3); pulse(4'd4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_clear_pulse", cnt_clear, 1);
        check("t5_abort_idle", busy, 0);
        check("t5_no_done", done, 0);
        tick();
        check("t5_clear_end", cnt_clear, 0);
        check("t5_q0", q, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_idle_abort", cnt_clear, 0);
        // edge arriving in LOAD is dropped; restart after abort works
        base = n_incr;
        start = 1'b1; start_val = 4'd7; stop_val = 4'd8;
        tick();
        start = 1'b0; step = 1'b1;
        tick();
        check("t6_load_edge", cnt_incr, 0);
        tick();
        check("t6_no_incr", cnt_incr, 0);
        check("t6_q", q, 7);
        check("t6_busy", busy, 1);
        step = 1'b0;
        tick();
        pulse(4'd8);
        tick();
        check("t6_done", done, 1);
        check("t6_incrs", n_incr - base, 1);
        tick();
        // clear during INCR after a wrap
        begin_seq(4'd15, 4'd2);
        step = 1'b1;
        tick();
        check("t7_incr", cnt_incr, 1);
        check("t7_wrap", wrapped, 1);
        clear = 1'b1; start = 1'b1; step = 1'b0;
        tick();
        check("t7_incr_clr", cnt_incr, 0);
        check("t7_busy_clr", busy, 0);
        check("t7_wrap_clr", wrapped, 0);
        check("t7_clear_net", cnt_clear, 0);
        check("t7_q_clr", q, 0);
        tick();
        check("t7_start_ign", busy, 0);
        check("t7_load_ign", cnt_load, 0);
        clear = 1'b0; start = 1'b0;
        tick();
        check("t7_idle", busy, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
